// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared encodings for the memory-access stage.
// Holds the mem_sel codes, FSM state type, exception bit positions and
// small decode helpers used by mem_stage and mem_align.
package mem_stage_pkg;

   // mem_sel codes presented by execute
   localparam logic [2:0] NOT_MEM = 3'd0;
   localparam logic [2:0] MEM_B   = 3'd1;
   localparam logic [2:0] MEM_BU  = 3'd2;
   localparam logic [2:0] MEM_H   = 3'd3;
   localparam logic [2:0] MEM_HU  = 3'd4;
   localparam logic [2:0] MEM_W   = 3'd5;

   // out_exc bit positions: {ades, adel}
   localparam int EXC_ADEL = 0;
   localparam int EXC_ADES = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_HOLD = 2'd3
   } state_e;

   // True for any code that touches the data bus; unused codes act as NOT_MEM.
   function automatic logic is_mem(input logic [2:0] sel);
      case (sel)
         MEM_B, MEM_BU, MEM_H, MEM_HU, MEM_W: return 1'b1;
         default:                             return 1'b0;
      endcase
   endfunction

   // Half with addr[0] set, or word with addr[1:0] nonzero.
   function automatic logic misaligned(input logic [2:0] sel, input logic [1:0] off);
      case (sel)
         MEM_H, MEM_HU: return off[0];
         MEM_W:         return (off != 2'b00);
         default:       return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align: combinational byte-lane steering for the memory stage.
// Stores: replicate sub-word data across lanes and build byte enables.
// Loads: pick the addressed byte/half and sign- or zero-extend it.
// BIG_ENDIAN=1 mirrors the lane order (byte offset k lives in lane 3-k).
// Misaligned halves/words are steered as if aligned (low offset bits ignored).
module mem_align
   import mem_stage_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b0
)(
   input  logic [2:0]  i_sel,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata
);

   logic [1:0]  w_lane;
   logic        w_hsel;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_lane = BIG_ENDIAN ? ~i_off : i_off;
   assign w_hsel = BIG_ENDIAN ? ~i_off[1] : i_off[1];
   assign w_byte = i_rdata[{w_lane, 3'b000} +: 8];
   assign w_half = i_rdata[{w_hsel, 4'b0000} +: 16];

   // Lane selection, store replication and load extension per access size
   always_comb begin
      o_be    = 4'b0000;
      o_wdata = i_wdata;
      o_rdata = i_rdata;
      case (i_sel)
         MEM_B, MEM_BU: begin
            o_be    = 4'b0001 << w_lane;
            o_wdata = {4{i_wdata[7:0]}};
            o_rdata = (i_sel == MEM_B) ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
         end
         MEM_H, MEM_HU: begin
            o_be    = w_hsel ? 4'b1100 : 4'b0011;
            o_wdata = {2{i_wdata[15:0]}};
            o_rdata = (i_sel == MEM_H) ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
         end
         MEM_W: begin
            o_be    = 4'b1111;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage MIPS pipeline.
// Takes execute's op, drives a req/gnt/rvalid data bus and hands a
// registered payload to writeback over valid/ready. Execute is stalled
// (in_ready low) while a bus access is outstanding or writeback is stalled.
// Optional: define MEM_ALIGN_CHECK_EN to trap misaligned half/word accesses
// (no bus access, out_exc flags adel/ades, out_result = faulting address);
// otherwise misaligned accesses are silently forced aligned.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b0
)(
   input  logic        clk,
   input  logic        resetn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_mem_sel,
   input  logic        in_store,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [31:0] in_result,
   input  logic [4:0]  in_wreg,
   input  logic        in_wen,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [3:0]  dbus_be,
   output logic [31:0] dbus_wdata,
   input  logic        dbus_gnt,
   input  logic        dbus_rvalid,
   input  logic [31:0] dbus_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [4:0]  out_wreg,
   output logic        out_wen,
   output logic [1:0]  out_exc
);

   state_e      r_state;
   logic [2:0]  r_sel;
   logic        r_store;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [4:0]  r_wreg;
   logic        r_wen;
   logic        r_req;
   logic [31:0] r_pend;
   logic        r_out_valid;
   logic [31:0] r_out_result;
   logic [4:0]  r_out_wreg;
   logic        r_out_wen;
   logic [1:0]  r_out_exc;

   logic        w_out_stall;
   logic        w_in_ready;
   logic        w_xfer;
   logic        w_misalign;
   logic [3:0]  w_be;
   logic [31:0] w_lane_wdata;
   logic [31:0] w_ld_data;

   assign w_out_stall = r_out_valid && !out_ready;
   assign w_in_ready  = (r_state == ST_IDLE) && !w_out_stall;
   assign w_xfer      = in_valid && w_in_ready;

`ifdef MEM_ALIGN_CHECK_EN
   assign w_misalign = misaligned(in_mem_sel, in_addr[1:0]);
`else
   assign w_misalign = 1'b0;
`endif

   // Bus fields derive from the latched op, so they stay stable through REQ.
   mem_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
      .i_sel   (r_sel),
      .i_off   (r_addr[1:0]),
      .i_wdata (r_wdata),
      .i_rdata (dbus_rdata),
      .o_be    (w_be),
      .o_wdata (w_lane_wdata),
      .o_rdata (w_ld_data)
   );

   assign in_ready   = w_in_ready;
   assign dbus_req   = r_req;
   assign dbus_we    = r_req && r_store;
   assign dbus_addr  = {r_addr[31:2], 2'b00};
   assign dbus_be    = w_be;
   assign dbus_wdata = w_lane_wdata;
   assign out_valid  = r_out_valid;
   assign out_result = r_out_result;
   assign out_wreg   = r_out_wreg;
   assign out_wen    = r_out_wen;
   assign out_exc    = r_out_exc;

   // Stage FSM: accept, run the bus access, and load the writeback payload
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state      <= ST_IDLE;
         r_sel        <= NOT_MEM;
         r_store      <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_wreg       <= '0;
         r_wen        <= 1'b0;
         r_req        <= 1'b0;
         r_pend       <= '0;
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_out_wreg   <= '0;
         r_out_wen    <= 1'b0;
         r_out_exc    <= 2'b00;
      end else begin
         // Payload consumed; a new payload below overrides this
         if (r_out_valid && out_ready)
            r_out_valid <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (w_xfer) begin
                  if (w_misalign) begin
                     r_out_valid           <= 1'b1;
                     r_out_result          <= in_addr;
                     r_out_wreg            <= in_wreg;
                     r_out_wen             <= 1'b0;
                     r_out_exc             <= 2'b00;
                     r_out_exc[EXC_ADES]   <= in_store;
                     r_out_exc[EXC_ADEL]   <= !in_store;
                  end else if (is_mem(in_mem_sel)) begin
                     r_sel   <= in_mem_sel;
                     r_store <= in_store;
                     r_addr  <= in_addr;
                     r_wdata <= in_wdata;
                     r_wreg  <= in_wreg;
                     r_wen   <= in_wen;
                     r_req   <= 1'b1;
                     r_state <= ST_REQ;
                  end else begin
                     r_out_valid  <= 1'b1;
                     r_out_result <= in_result;
                     r_out_wreg   <= in_wreg;
                     r_out_wen    <= in_wen;
                     r_out_exc    <= 2'b00;
                  end
               end
            end
            ST_REQ: begin
               // rvalid is not sampled here: only data after gnt counts
               if (dbus_gnt) begin
                  r_req <= 1'b0;
                  if (!r_store) begin
                     r_state <= ST_WAIT;
                  end else if (w_out_stall) begin
                     r_pend  <= r_addr;
                     r_state <= ST_HOLD;
                  end else begin
                     // Store payload carries the address; it never writes a register
                     r_out_valid  <= 1'b1;
                     r_out_result <= r_addr;
                     r_out_wreg   <= r_wreg;
                     r_out_wen    <= 1'b0;
                     r_out_exc    <= 2'b00;
                     r_state      <= ST_IDLE;
                  end
               end
            end
            ST_WAIT: begin
               if (dbus_rvalid) begin
                  if (w_out_stall) begin
                     r_pend  <= w_ld_data;
                     r_state <= ST_HOLD;
                  end else begin
                     r_out_valid  <= 1'b1;
                     r_out_result <= w_ld_data;
                     r_out_wreg   <= r_wreg;
                     r_out_wen    <= r_wen;
                     r_out_exc    <= 2'b00;
                     r_state      <= ST_IDLE;
                  end
               end
            end
            ST_HOLD: begin
               if (!w_out_stall) begin
                  r_out_valid  <= 1'b1;
                  r_out_result <= r_pend;
                  r_out_wreg   <= r_wreg;
                  r_out_wen    <= r_store ? 1'b0 : r_wen;
                  r_out_exc    <= 2'b00;
                  r_state      <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage.
// Stimulus pushes expected writeback payloads and bus requests into queues;
// a bus responder and a writeback monitor pop and compare independently.
// Reference: byte-addressed little-endian arithmetic on a word memory map.
module tb_mem_stage;

   localparam logic [2:0] S_NOT = 3'd0, S_B = 3'd1, S_BU = 3'd2,
                          S_H = 3'd3, S_HU = 3'd4, S_W = 3'd5;

   typedef struct {
      logic [31:0] res;
      logic        chk_res;
      logic [4:0]  wreg;
      logic        wen;
      logic [1:0]  exc;
   } out_t;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
   } bus_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_mem_sel = '0;
   logic        in_store = 1'b0;
   logic [31:0] in_addr = '0, in_wdata = '0, in_result = '0;
   logic [4:0]  in_wreg = '0;
   logic        in_wen = 1'b0;
   logic        dbus_req, dbus_we;
   logic [31:0] dbus_addr, dbus_wdata;
   logic [3:0]  dbus_be;
   logic        dbus_gnt = 1'b0, dbus_rvalid = 1'b0;
   logic [31:0] dbus_rdata = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_result;
   logic [4:0]  out_wreg;
   logic        out_wen;
   logic [1:0]  out_exc;

   int   checks = 0;
   int   errors = 0;
   out_t exp_out[$];
   bus_t exp_bus[$];
   logic [31:0] mem [logic [31:0]];
   int   ready_mode = 0;   // 0 random, 1 always ready, 2 held low
   int   rv_force = 0;     // nonzero: fixed rvalid delay after gnt

   mem_stage dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .in_mem_sel(in_mem_sel), .in_store(in_store), .in_addr(in_addr),
      .in_wdata(in_wdata), .in_result(in_result), .in_wreg(in_wreg), .in_wen(in_wen),
      .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
      .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
      .dbus_rdata(dbus_rdata), .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_wreg(out_wreg), .out_wen(out_wen), .out_exc(out_exc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rd_word(input logic [31:0] wa);
      if (mem.exists(wa)) return mem[wa];
      return (wa * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   // Load value from byte-addressed arithmetic (little-endian)
   function automatic logic [31:0] ld_val(input logic [2:0] sel, input logic [31:0] a);
      logic [31:0] w, v;
      w = rd_word(a & ~32'd3);
      v = w;
      if (sel == S_B || sel == S_BU) begin
         v = (w >> (8 * (a % 4))) & 32'd255;
         if (sel == S_B && v >= 32'd128) v = v - 32'd256;
      end else if (sel == S_H || sel == S_HU) begin
         v = (w >> (8 * (a & 32'd2))) & 32'd65535;
         if (sel == S_H && v >= 32'd32768) v = v - 32'd65536;
      end
      return v;
   endfunction

   function automatic logic is_misaligned(input logic [2:0] sel, input logic [31:0] a);
      return ((sel == S_H || sel == S_HU) && (a % 2 != 0)) || (sel == S_W && (a % 4 != 0));
   endfunction

   // Present one op (caller is at negedge+1); returns cycles spent waiting
   task automatic issue(input logic [2:0] sel, input logic st, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] res,
                        input logic [4:0] wr, input logic we, output int waited);
      out_t o;
      bus_t b;
      logic trap;
      in_valid = 1'b1; in_mem_sel = sel; in_store = st; in_addr = a;
      in_wdata = wd; in_result = res; in_wreg = wr; in_wen = we;
      waited = 0;
      while (!in_ready) begin
         @(negedge clk); #1;
         waited++;
         if (waited > 300) begin
            chk("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
         end
      end
`ifdef MEM_ALIGN_CHECK_EN
      trap = (sel != S_NOT) && is_misaligned(sel, a);
`else
      trap = 1'b0;
`endif
      if (trap) begin
         o = '{res: a, chk_res: 1'b1, wreg: wr, wen: 1'b0, exc: st ? 2'b10 : 2'b01};
         exp_out.push_back(o);
      end else if (sel != S_NOT) begin
         b.addr = a & ~32'd3;
         b.we   = st;
         if (sel == S_B || sel == S_BU) begin
            b.be = 4'(32'd1 << (a % 4));
            b.wdata = (wd & 32'd255) * 32'h01010101;
         end else if (sel == S_H || sel == S_HU) begin
            b.be = 4'(32'd3 << (a & 32'd2));
            b.wdata = (wd & 32'd65535) * 32'h00010001;
         end else begin
            b.be = 4'hF;
            b.wdata = wd;
         end
         exp_bus.push_back(b);
         o = '{res: st ? 32'd0 : ld_val(sel, a), chk_res: !st, wreg: wr,
               wen: st ? 1'b0 : we, exc: 2'b00};
         exp_out.push_back(o);
      end else begin
         o = '{res: res, chk_res: 1'b1, wreg: wr, wen: we, exc: 2'b00};
         exp_out.push_back(o);
      end
      @(negedge clk); #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin @(negedge clk); #1; end
   endtask

   task automatic drain();
      int t = 0;
      in_valid = 1'b0;
      while (exp_out.size() != 0 || exp_bus.size() != 0 || out_valid) begin
         @(negedge clk); #1;
         t++;
         if (t > 500) begin
            chk("drain_timeout", 32'(exp_out.size()), 32'd0);
            exp_out.delete(); exp_bus.delete();
            return;
         end
      end
   endtask

   // Bus responder: checks each new request, grants after a random delay,
   // returns read data later; injects junk rvalid before gnt
   initial begin
      bus_t b;
      int   rv_cnt = 0;
      int   req_wait = 0;
      logic [31:0] rv_addr = '0;
      logic seen = 1'b0;
      forever begin
         @(negedge clk); #1;
         dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = $urandom;
         if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
               dbus_rvalid = 1'b1;
               dbus_rdata  = rd_word(rv_addr);
            end
         end else if (dbus_req && resetn) begin
            chk("in_ready_during_req", 32'(in_ready), 32'd0);
            if (!seen) begin
               seen = 1'b1;
               req_wait = 0;
               if (exp_bus.size() == 0) begin
                  chk("unexpected_req", 32'(dbus_req), 32'd0);
               end else begin
                  b = exp_bus.pop_front();
                  chk("bus_addr", dbus_addr, b.addr);
                  chk("bus_be", 32'(dbus_be), 32'(b.be));
                  chk("bus_we", 32'(dbus_we), 32'(b.we));
                  if (b.we) chk("bus_wdata", dbus_wdata, b.wdata);
               end
            end
            if ($urandom_range(2) == 0 || req_wait >= 4) begin
               dbus_gnt = 1'b1;
               seen = 1'b0;
               if (!dbus_we) begin
                  rv_cnt  = (rv_force != 0) ? rv_force : 1 + $urandom_range(2);
                  rv_addr = dbus_addr;
               end
            end else if ($urandom_range(3) == 0) begin
               dbus_rvalid = 1'b1;   // before gnt: must be ignored
            end
            req_wait++;
         end else begin
            seen = 1'b0;
         end
      end
   end

   // Writeback monitor: drives out_ready, checks stall stability and payloads
   initial begin
      out_t o;
      logic        prev_stall = 1'b0;
      logic [31:0] prev_res = '0;
      logic [4:0]  prev_wreg = '0;
      logic        prev_wen = 1'b0;
      forever begin
         @(negedge clk);
         case (ready_mode)
            1:       out_ready = 1'b1;
            2:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(3) != 0);
         endcase
         #1;
         if (!resetn) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("stall_valid", 32'(out_valid), 32'd1);
               chk("stall_result", out_result, prev_res);
               chk("stall_wreg", 32'(out_wreg), 32'(prev_wreg));
               chk("stall_wen", 32'(out_wen), 32'(prev_wen));
            end
            if (out_valid && !out_ready)
               chk("in_ready_while_stalled", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
               if (exp_out.size() == 0) begin
                  chk("unexpected_out_valid", 32'(out_valid), 32'd0);
               end else begin
                  o = exp_out.pop_front();
                  if (o.chk_res) chk("out_result", out_result, o.res);
                  chk("out_wreg", 32'(out_wreg), 32'(o.wreg));
                  chk("out_wen", 32'(out_wen), 32'(o.wen));
                  chk("out_exc", 32'(out_exc), 32'(o.exc));
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = out_result;
            prev_wreg  = out_wreg;
            prev_wen   = out_wen;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int t;
      logic [2:0] sel;
      resetn = 1'b0;
      ready_mode = 1;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      #1;
      // Reset state
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_dbus_req", 32'(dbus_req), 32'd0);
      chk("rst_dbus_we", 32'(dbus_we), 32'd0);
      chk("rst_dbus_be", 32'(dbus_be), 32'd0);
      chk("rst_out_result", out_result, 32'd0);
      chk("rst_out_wen", 32'(out_wen), 32'd0);
      chk("rst_out_exc", 32'(out_exc), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // NOT_MEM back-to-back at full throughput
      for (int i = 0; i < 4; i++) begin
         issue(S_NOT, 1'b0, 32'd0, 32'd0, 32'h12345678, 5'(i + 1), 1'b1, w);
         chk("notmem_no_wait", 32'(w), 32'd0);
      end
      drain();

      // SB to 0x103
      issue(S_B, 1'b1, 32'h103, 32'h000000AB, 32'd0, 5'd7, 1'b1, w);
      drain();

      // Sub-word loads
      mem[32'h100] = 32'h00800000;
      issue(S_B, 1'b0, 32'h102, 32'd0, 32'd0, 5'd3, 1'b1, w);
      issue(S_BU, 1'b0, 32'h102, 32'd0, 32'd0, 5'd4, 1'b1, w);
      drain();
      mem[32'h100] = 32'h80010000;
      issue(S_HU, 1'b0, 32'h102, 32'd0, 32'd0, 5'd5, 1'b1, w);
      issue(S_H, 1'b0, 32'h102, 32'd0, 32'd0, 5'd6, 1'b1, w);
      drain();

      // LW with writeback stalled after the data returns
      mem[32'h100] = 32'hCAFEF00D;
      ready_mode = 2;
      issue(S_W, 1'b0, 32'h100, 32'd0, 32'd0, 5'd9, 1'b1, w);
      in_valid = 1'b0;
      t = 0;
      while (!out_valid && t < 50) begin @(negedge clk); #1; t++; end
      chk("lw_valid_arrives", 32'(out_valid), 32'd1);
      repeat (3) begin
         @(negedge clk); #1;
         chk("lw_hold_in_ready", 32'(in_ready), 32'd0);
      end
      ready_mode = 1;
      drain();

      // Misaligned accesses (trapped or forced aligned depending on build)
      issue(S_W, 1'b0, 32'h102, 32'd0, 32'd0, 5'd10, 1'b1, w);
      issue(S_H, 1'b1, 32'h105, 32'h0000BEEF, 32'd0, 5'd11, 1'b1, w);
      issue(S_HU, 1'b0, 32'h107, 32'd0, 32'd0, 5'd12, 1'b1, w);
      drain();

      // Reset while waiting for read data
      rv_force = 3;
      issue(S_W, 1'b0, 32'h140, 32'd0, 32'd0, 5'd13, 1'b1, w);
      in_valid = 1'b0;
      t = 0;
      while (!dbus_gnt && t < 50) begin @(negedge clk); #2; t++; end
      chk("rst_test_gnt_seen", 32'(dbus_gnt), 32'd1);
      @(negedge clk);
      resetn = 1'b0;
      exp_out.delete();
      exp_bus.delete();
      @(negedge clk);
      resetn = 1'b1;
      #1;
      chk("midrst_dbus_req", 32'(dbus_req), 32'd0);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      repeat (6) begin
         @(negedge clk); #1;
         chk("late_rvalid_ignored", 32'(out_valid), 32'd0);
      end
      rv_force = 0;

      // Randomized mix with random ready and bubbles
      ready_mode = 0;
      for (int i = 0; i < 200; i++) begin
         sel = 3'($urandom_range(5));
         issue(sel, 1'($urandom_range(1)), 32'h200 + 32'($urandom_range(255)),
               $urandom, $urandom, 5'($urandom), 1'($urandom_range(1)), w);
         if ($urandom_range(3) == 0) idle(1 + $urandom_range(2));
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the five-stage MIPS core, directly downstream of execute.
- Consumes execute's mem_sel, effective address, store data and ALU result, and drives a request/grant/response data bus.
- Performs byte-lane alignment for stores and extract/extend for loads.
- Hands a registered result to writeback over a valid/ready handshake and stalls execute while a bus access is outstanding.

Parameters:
BIG_ENDIAN, 0, lane mapping: 0 puts byte at addr[1:0]=k in lane k, 1 puts it in lane 3-k.

Ports:
clk  in  1  core clock
resetn  in  1  synchronous, active-low reset
in_valid  in  1  execute presents an instruction
in_ready  out  1  stage accepts it this cycle
in_mem_sel  in  3  NOT_MEM/MEM_B/MEM_BU/MEM_H/MEM_HU/MEM_W code from defs.vh
in_store  in  1  1 = store, 0 = load (ignored when NOT_MEM)
in_addr  in  32  effective address
in_wdata  in  32  store data; only the low byte/half is used for sub-word stores
in_result  in  32  ALU result for non-memory ops
in_wreg  in  5  destination register
in_wen  in  1  instruction writes a register
dbus_req  out  1  bus request
dbus_we  out  1  write strobe
dbus_addr  out  32  word address, bits [1:0] = 0
dbus_be  out  4  byte enables
dbus_wdata  out  32  lane-aligned store data
dbus_gnt  in  1  request accepted this cycle
dbus_rvalid  in  1  read data valid
dbus_rdata  in  32  read data
out_valid  out  1  writeback payload valid
out_ready  in  1  writeback accepts the payload
out_result  out  32  load data or passed-through result
out_wreg  out  5  destination register
out_wen  out  1  register write enable (forced 0 for stores)
out_exc  out  2  {ades, adel}; only with feature, else tie 0

Behaviour:
- Reset: state IDLE; dbus_req, dbus_we, out_valid, out_wen, out_exc = 0; dbus_be = 0; out_result = 0.
- Reset mid-access: request dropped at the next edge; a late rvalid/gnt after reset is ignored.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Transfer occurs when in_valid && in_ready.
- States: IDLE, REQ, WAIT, HOLD.
- NOT_MEM transfer: out_result <= in_result, out_valid <= 1 next edge; remain IDLE. Latency 1, full throughput.
- Memory transfer: latch all fields. Next cycle go to REQ with dbus_req=1 and bus fields stable. Hold REQ until dbus_gnt.
  - Store: on gnt, out_valid <= 1, out_wen <= 0, go to IDLE (or HOLD if out_valid is still stalled).
  - Load: on gnt, go to WAIT. On dbus_rvalid, out_result <= extract(rdata) and out_valid <= 1.
- rvalid in the same cycle as gnt is legal only for the next cycle's sampling; rvalid before gnt is ignored.
- HOLD: entered when the payload is ready but out_valid is stalled (out_valid && !out_ready). Release to IDLE when out_ready.
- out_valid drops after the out_valid && out_ready handshake unless a new payload loads in the same cycle.
- Store lanes (k = addr[1:0]):
  - B: wdata = {4{wdata[7:0]}}, be = 1<<k.
  - H: wdata = {2{wdata[15:0]}}, be = 4'b0011<<(2*addr[1]).
  - W: be = 4'b1111.
  - Loads drive be the same way.
- Load extract: select the addressed byte/half; sign-extend for B/H, zero-extend for BU/HU; W passes through.
- Without the feature, misaligned addresses are forced aligned: H ignores addr[0], W ignores addr[1:0].

Optional Feature:
- MEM_ALIGN_CHECK_EN defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, issues no bus request.
  - out_valid follows 1 cycle later with out_wen=0; out_exc = 2'b01 for a load, 2'b10 for a store; out_result = the faulting address.
- Not defined: out_exc = 0 and force-align as described in Behaviour.

Decomposition:
- defs.vh (shared): MEM_* codes (NOT_MEM, MEM_B, MEM_BU, MEM_H, MEM_HU, MEM_W), FSM state encodings, EXC_ADEL/EXC_ADES bits.
- One combinational sub-module, mem_align: store lane/be generation and load extract/extend, parameterised by BIG_ENDIAN.

Test Plan:
- NOT_MEM back-to-back, in_result=0x1234_5678, out_ready=1 -> out_valid every cycle, out_result=0x1234_5678, in_ready stays 1.
- SB addr=0x103, wdata=0xAB, gnt after 2 cycles -> dbus_addr=0x100, be=4'b1000, wdata=0xABABABAB; in_ready low until the store completes; out_wen=0.
- LB addr=0x102, rdata=0x0080_0000 -> out_result=0xFFFF_FF80; LBU same -> 0x0000_0080; LHU addr=0x102, rdata=0x8001_0000 -> 0x0000_8001.
- LW with out_ready=0 for 3 cycles after rvalid -> out_valid and out_result=rdata held stable; in_ready=0 until release.
- resetn=0 while in WAIT -> dbus_req=0, out_valid=0 next edge; a following rvalid produces no output.
- MEM_ALIGN_CHECK_EN, LW addr=0x102 -> no dbus_req, out_exc=2'b01, out_result=0x102, out_wen=0.
